// File: rtl/router_pkg.sv
// Shared defaults for the input/output router FIFOs.
package router_pkg;

  localparam int PISO_DEPTH      = 8;
  localparam int PISO_DATA_WIDTH = 8;

endpackage

// File: rtl/piso_slot.sv
// One DEPTH-word vector register bank with a load enable and a word-select mux.
module piso_slot #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_load,
  input  logic [DEPTH*DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0]       i_sel,
  output logic [DEPTH*DATA_WIDTH-1:0] o_data,
  output logic [DATA_WIDTH-1:0]       o_word
);

  logic [DEPTH*DATA_WIDTH-1:0] mem;

  // Data is qualified by the owner's valid bit, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (i_load) mem <= i_data;
  end

  assign o_data = mem;
  assign o_word = mem[i_sel*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/piso_fifo.sv
// Two-slot parallel-in serial-out FIFO: slot A drains word by word while slot P
// holds the next vector, so consecutive vectors stream without a bubble.
module piso_fifo
  import router_pkg::*;
#(
  parameter int DEPTH      = PISO_DEPTH,
  parameter int DATA_WIDTH = PISO_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(2*DEPTH+1)
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic                        i_clear,
  input  logic                        i_wen,
  input  logic [DEPTH*DATA_WIDTH-1:0] i_data_in,
  input  logic                        i_ren,
  output logic [DATA_WIDTH-1:0]       o_data_out,
  output logic                        o_valid,
  output logic                        o_last,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [CNT_WIDTH-1:0]        o_count,
  output logic                        o_overflow,
  output logic                        o_underflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH-1);

  logic                        a_vld;
  logic                        p_vld;
  logic [ADDR_WIDTH-1:0]       rd_ptr;
  logic                        wr_acc;
  logic                        rd_acc;
  logic                        a_done;
  logic                        a_load;
  logic                        p_load;
  logic [DEPTH*DATA_WIDTH-1:0] a_din;
  logic [DEPTH*DATA_WIDTH-1:0] p_vec;
  logic [DEPTH*DATA_WIDTH-1:0] a_vec_unused;
  logic [DATA_WIDTH-1:0]       a_word;
  logic [DATA_WIDTH-1:0]       p_word_unused;

  assign o_empty = !a_vld;
  assign o_full  = a_vld && p_vld;
  assign wr_acc  = i_wen && !o_full;
  assign rd_acc  = i_ren && a_vld;
  assign a_done  = rd_acc && (rd_ptr == LAST_PTR);

  // A refills from P when it finishes with P waiting, otherwise from the write port.
  assign a_din  = (a_done && p_vld) ? p_vec : i_data_in;
  assign a_load = !i_clear &&
                  ((a_done && p_vld) || (a_done && wr_acc) || (!a_vld && wr_acc));
  assign p_load = !i_clear && wr_acc &&
                  ((a_done && p_vld) || (!a_done && a_vld && !p_vld));

  always_comb begin
    o_count = '0;
    if (a_vld) o_count = CNT_WIDTH'(DEPTH) - CNT_WIDTH'(rd_ptr);
    if (p_vld) o_count = o_count + CNT_WIDTH'(DEPTH);
  end

  piso_slot #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_slot_a (
    .i_clk  (i_clk),
    .i_load (a_load),
    .i_data (a_din),
    .i_sel  (rd_ptr),
    .o_data (a_vec_unused),
    .o_word (a_word)
  );

  piso_slot #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_slot_p (
    .i_clk  (i_clk),
    .i_load (p_load),
    .i_data (i_data_in),
    .i_sel  (rd_ptr),
    .o_data (p_vec),
    .o_word (p_word_unused)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      a_vld       <= 1'b0;
      p_vld       <= 1'b0;
      rd_ptr      <= '0;
      o_data_out  <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_clear) begin
      a_vld       <= 1'b0;
      p_vld       <= 1'b0;
      rd_ptr      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_valid <= rd_acc;
      o_last  <= a_done;
      if (rd_acc) begin
        o_data_out <= a_word;
        rd_ptr     <= rd_ptr + 1'b1;
      end
      if (i_wen && o_full)   o_overflow  <= 1'b1;
      if (i_ren && !a_vld)   o_underflow <= 1'b1;

      if (a_done) begin
        a_vld <= p_vld || wr_acc;
        p_vld <= p_vld && wr_acc;
      end else if (!a_vld) begin
        if (wr_acc) begin
          a_vld  <= 1'b1;
          rd_ptr <= '0;
        end
      end else if (!p_vld) begin
        if (wr_acc) p_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_fifo.sv
// Directed table-driven bench for piso_fifo (DEPTH=8, DATA_WIDTH=8).
module tb_piso_fifo;

  logic        clk;
  logic        nrst;
  logic        clear;
  logic        wen;
  logic [63:0] data_in;
  logic        ren;
  logic [7:0]  data_out;
  logic        valid;
  logic        last;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        ovf;
  logic        udf;

  int errors = 0;
  int checks = 0;

  piso_fifo #(.DEPTH(8), .DATA_WIDTH(8)) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_clear     (clear),
    .i_wen       (wen),
    .i_data_in   (data_in),
    .i_ren       (ren),
    .o_data_out  (data_out),
    .o_valid     (valid),
    .o_last      (last),
    .o_empty     (empty),
    .o_full      (full),
    .o_count     (count),
    .o_overflow  (ovf),
    .o_underflow (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic        ren;
    logic        clr;
    logic [63:0] data;
    logic        e_valid;
    logic        e_last;
    logic [7:0]  e_dout;
    logic [4:0]  e_cnt;
    logic        e_empty;
    logic        e_full;
    logic        e_ovf;
    logic        e_udf;
  } row_t;

  row_t tbl[$];

  function automatic logic [63:0] mk(input logic [7:0] base);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = base + 8'(k);
    return v;
  endfunction

  task automatic add(input logic w, input logic r, input logic c, input logic [63:0] d,
                     input logic ev, input logic el, input logic [7:0] ed, input int ec,
                     input logic ee, input logic ef, input logic eo, input logic eu);
    row_t x;
    x.wen = w; x.ren = r; x.clr = c; x.data = d;
    x.e_valid = ev; x.e_last = el; x.e_dout = ed; x.e_cnt = 5'(ec);
    x.e_empty = ee; x.e_full = ef; x.e_ovf = eo; x.e_udf = eu;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input row_t x);
    chk("valid", idx, 32'(valid), 32'(x.e_valid));
    chk("last",  idx, 32'(last),  32'(x.e_last));
    if (x.e_valid) chk("dout", idx, 32'(data_out), 32'(x.e_dout));
    chk("count", idx, 32'(count), 32'(x.e_cnt));
    chk("empty", idx, 32'(empty), 32'(x.e_empty));
    chk("full",  idx, 32'(full),  32'(x.e_full));
    chk("ovf",   idx, 32'(ovf),   32'(x.e_ovf));
    chk("udf",   idx, 32'(udf),   32'(x.e_udf));
  endtask

  task automatic run_rows(input int first, input int last_idx);
    for (int i = first; i < last_idx; i++) begin
      wen = tbl[i].wen; ren = tbl[i].ren; clear = tbl[i].clr; data_in = tbl[i].data;
      @(posedge clk);
      #1;
      check_outs(i, tbl[i]);
    end
    wen = 1'b0; ren = 1'b0; clear = 1'b0;
  endtask

  int split;

  initial begin
    // Single vector
    add(1,0,0, mk(8'h10), 0,0,8'h00, 8, 0,0,0,0);
    for (int i = 0; i < 8; i++)
      add(0,1,0, 64'h0, 1, i==7, 8'(8'h10+i), 7-i, i==7, 0,0,0);
    add(0,0,0, 64'h0, 0,0,8'h00, 0, 1,0,0,0);
    // Ping-pong
    add(1,0,0, mk(8'h00), 0,0,8'h00, 8,  0,0,0,0);
    add(1,0,0, mk(8'h80), 0,0,8'h00, 16, 0,1,0,0);
    for (int i = 0; i < 16; i++)
      add(0,1,0, 64'h0, 1, (i==7)||(i==15), (i < 8) ? 8'(i) : 8'(8'h80+i-8),
          15-i, i==15, i<7, 0,0);
    // Write on the last read of A with P empty
    add(1,0,0, mk(8'h20), 0,0,8'h00, 8, 0,0,0,0);
    for (int i = 0; i < 7; i++)
      add(0,1,0, 64'h0, 1,0, 8'(8'h20+i), 7-i, 0,0,0,0);
    add(1,1,0, mk(8'h40), 1,1,8'h27, 8, 0,0,0,0);
    for (int i = 0; i < 8; i++)
      add(0,1,0, 64'h0, 1, i==7, 8'(8'h40+i), 7-i, i==7, 0,0,0);
    // Overflow, including a write while full on the cycle A finishes
    add(1,0,0, mk(8'h50), 0,0,8'h00, 8,  0,0,0,0);
    add(1,0,0, mk(8'h60), 0,0,8'h00, 16, 0,1,0,0);
    add(1,0,0, mk(8'h70), 0,0,8'h00, 16, 0,1,1,0);
    for (int i = 0; i < 7; i++)
      add(0,1,0, 64'h0, 1,0, 8'(8'h50+i), 15-i, 0,1,1,0);
    add(1,1,0, mk(8'h90), 1,1,8'h57, 8, 0,0,1,0);
    for (int i = 0; i < 8; i++)
      add(0,1,0, 64'h0, 1, i==7, 8'(8'h60+i), 7-i, i==7, 0,1,0);
    add(0,0,0, 64'h0, 0,0,8'h00, 0, 1,0,1,0);
    // Clear, then underflow
    add(0,0,1, 64'h0, 0,0,8'h00, 0, 1,0,0,0);
    add(0,1,0, 64'h0, 0,0,8'h00, 0, 1,0,0,1);
    add(0,0,1, 64'h0, 0,0,8'h00, 0, 1,0,0,0);
    // Clear beats simultaneous write and read mid-drain
    add(1,0,0, mk(8'hA0), 0,0,8'h00, 8,  0,0,0,0);
    add(1,0,0, mk(8'hB0), 0,0,8'h00, 16, 0,1,0,0);
    add(1,0,0, mk(8'hC0), 0,0,8'h00, 16, 0,1,1,0);
    for (int i = 0; i < 3; i++)
      add(0,1,0, 64'h0, 1,0, 8'(8'hA0+i), 15-i, 0,1,1,0);
    add(1,1,1, mk(8'hC8), 0,0,8'h00, 0, 1,0,0,0);
    add(0,0,0, 64'h0, 0,0,8'h00, 0, 1,0,0,0);
    // Build-up before the async reset
    split = tbl.size();
    add(1,0,0, mk(8'hC0), 0,0,8'h00, 8,  0,0,0,0);
    add(1,0,0, mk(8'hE0), 0,0,8'h00, 16, 0,1,0,0);
    add(1,0,0, mk(8'hF0), 0,0,8'h00, 16, 0,1,1,0);
    for (int i = 0; i < 5; i++)
      add(0,1,0, 64'h0, 1,0, 8'(8'hC0+i), 15-i, 0,1,1,0);
    // After reset release: fresh vector from word 0
    add(1,0,0, mk(8'hD0), 0,0,8'h00, 8, 0,0,0,0);
    for (int i = 0; i < 8; i++)
      add(0,1,0, 64'h0, 1, i==7, 8'(8'hD0+i), 7-i, i==7, 0,0,0);

    nrst = 1'b0; clear = 1'b0; wen = 1'b0; ren = 1'b0; data_in = '0;
    #2;
    chk("rst_empty", -1, 32'(empty), 32'd1);
    chk("rst_full",  -1, 32'(full),  32'd0);
    chk("rst_count", -1, 32'(count), 32'd0);
    chk("rst_valid", -1, 32'(valid), 32'd0);
    chk("rst_dout",  -1, 32'(data_out), 32'd0);
    chk("rst_ovf",   -1, 32'(ovf),   32'd0);
    chk("rst_udf",   -1, 32'(udf),   32'd0);
    @(negedge clk);
    nrst = 1'b1;

    run_rows(0, split + 8);

    // Async reset between edges with rd_ptr=5, P loaded, overflow set
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_empty", -2, 32'(empty), 32'd1);
    chk("arst_full",  -2, 32'(full),  32'd0);
    chk("arst_count", -2, 32'(count), 32'd0);
    chk("arst_valid", -2, 32'(valid), 32'd0);
    chk("arst_last",  -2, 32'(last),  32'd0);
    chk("arst_dout",  -2, 32'(data_out), 32'd0);
    chk("arst_ovf",   -2, 32'(ovf),   32'd0);
    @(negedge clk);
    nrst = 1'b1;

    run_rows(split + 8, tbl.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
